// File: rtl/mem_ram_fifo_ctrl.sv
// mem_ram_fifo_ctrl
// Valid/ready FIFO controller in front of a two-port RAM macro with a fixed
// read latency. Words are written to the RAM on push, read ahead of demand
// under a credit limit, and captured into a small staging buffer that feeds
// the consumer. The macro latency is therefore hidden: once primed, one word
// per clock flows in and out with no bubbles.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   push_valid/ready/data    producer side
//   pop_valid/ready/data     consumer side; pop_data is registered storage
//   ram_wr_en/addr/data      RAM write port (ram_wr_data mirrors push_data)
//   ram_rd_en/addr           RAM read request
//   ram_rd_data              RAM read data, RD_LAT clocks after the request
//   count                    words held (RAM + in flight + staging)
module mem_ram_fifo_ctrl #(
  parameter int WIDTH     = 73,
  parameter int DEPTH     = 12,
  parameter int AW        = 4,
  parameter int RD_LAT    = 2,
  parameter int OUT_DEPTH = 3,
  parameter int CW        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic             ram_wr_en,
  output logic [AW-1:0]    ram_wr_addr,
  output logic [WIDTH-1:0] ram_wr_data,
  output logic             ram_rd_en,
  output logic [AW-1:0]    ram_rd_addr,
  input  logic [WIDTH-1:0] ram_rd_data,
  output logic [CW-1:0]    count
);

  localparam int RCW = $clog2(DEPTH + 1);
  localparam int OCW = $clog2(OUT_DEPTH + 1);
  localparam int OPW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int ICW = $clog2(RD_LAT + 1);
  localparam int SW  = OCW + ICW + 1;

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [RCW-1:0]   ram_cnt;
  logic [RD_LAT-1:0] rd_pipe;
  logic [ICW-1:0]   inflight;
  logic [OCW-1:0]   out_cnt;
  logic [OPW-1:0]   head;
  logic [OPW-1:0]   tail;
  logic [WIDTH-1:0] stage_mem [OUT_DEPTH];

  logic             push_fire;
  logic             pop_fire;
  logic             rd_issue;
  logic             capture;
  logic [SW-1:0]    credit_use;

  function automatic logic [AW-1:0] ram_ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [OPW-1:0] stage_ptr_inc(input logic [OPW-1:0] p);
    return (p == OPW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reads in flight are exactly the set bits of the return pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + ICW'(rd_pipe[i]);
    end
  end

  // push_ready is forced low while reset is asserted.
  assign push_ready  = ~rst & (ram_cnt < RCW'(DEPTH));
  assign push_fire   = push_valid & push_ready;
  assign pop_valid   = (out_cnt != '0);
  assign pop_fire    = pop_valid & pop_ready;
  assign pop_data    = stage_mem[head];

  // A read may issue only if its data is guaranteed a staging slot on return,
  // counting the slot that a same-cycle pop frees.
  assign credit_use  = SW'(out_cnt) + SW'(inflight) - SW'(pop_fire);
  assign rd_issue    = (ram_cnt != '0) & (credit_use < SW'(OUT_DEPTH));
  assign capture     = rd_pipe[RD_LAT-1];

  assign ram_wr_en   = push_fire;
  assign ram_wr_addr = wptr;
  assign ram_wr_data = push_data;
  assign ram_rd_en   = rd_issue;
  assign ram_rd_addr = rptr;

  assign count = CW'(ram_cnt) + CW'(inflight) + CW'(out_cnt);

  // Control state: pointers, occupancy counters and the read-return pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      rd_pipe <= '0;
      out_cnt <= '0;
      head    <= '0;
      tail    <= '0;
    end else begin
      if (push_fire) wptr <= ram_ptr_inc(wptr);
      if (rd_issue)  rptr <= ram_ptr_inc(rptr);
      // A word written this edge becomes visible to rd_issue next cycle only.
      ram_cnt <= ram_cnt + RCW'(push_fire) - RCW'(rd_issue);
      rd_pipe <= (rd_pipe << 1) | RD_LAT'(rd_issue);
      if (capture)  tail <= stage_ptr_inc(tail);
      if (pop_fire) head <= stage_ptr_inc(head);
      out_cnt <= out_cnt + OCW'(capture) - OCW'(pop_fire);
    end
  end

  // Staging stage: RAM return data lands here; storage is not reset.
  always_ff @(posedge clk) begin
    if (capture) stage_mem[tail] <= ram_rd_data;
  end

  staging_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(capture && !pop_fire && (out_cnt == OCW'(OUT_DEPTH))));

endmodule

// File: tb/tb_mem_ram_fifo_ctrl.sv
module tb_mem_ram_fifo_ctrl;
  localparam int WIDTH = 73;
  localparam int DEPTH = 12;
  localparam int AW    = 4;
  localparam int CW    = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             push_valid;
  logic             push_ready;
  logic [WIDTH-1:0] push_data;
  logic             pop_valid;
  logic             pop_ready;
  logic [WIDTH-1:0] pop_data;
  logic             ram_wr_en;
  logic [AW-1:0]    ram_wr_addr;
  logic [WIDTH-1:0] ram_wr_data;
  logic             ram_rd_en;
  logic [AW-1:0]    ram_rd_addr;
  logic [WIDTH-1:0] ram_rd_data;
  logic [CW-1:0]    count;

  int checks = 0;
  int errors = 0;
  int popped = 0;
  int wr_total = 0;
  int rd_total = 0;
  logic             hold_prev = 1'b0;
  logic [WIDTH-1:0] held_data;
  logic [WIDTH-1:0] q[$];

  always #5 clk = ~clk;

  mem_ram_fifo_ctrl dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .count(count)
  );

  // RAM macro model: request sampled at one edge, data out after the next.
  logic [WIDTH-1:0] ram [DEPTH];
  logic [AW-1:0]    rq_addr;
  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    rq_addr     <= ram_rd_addr;
    ram_rd_data <= ram[rq_addr];
  end

  // Reference model: a plain FIFO of accepted words; sequential RAM addresses.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (count !== CW'(q.size())) begin
        errors++; $display("FAIL count_track: got %0d expected %0d", count, q.size());
      end
      if (hold_prev) begin
        checks++;
        if (pop_valid !== 1'b1 || pop_data !== held_data) begin
          errors++; $display("FAIL pop_hold: got v=%0b d=%h expected v=1 d=%h", pop_valid, pop_data, held_data);
        end
      end
      if (pop_valid && pop_ready) begin
        checks++;
        if (q.size() == 0 || pop_data !== q[0]) begin
          errors++; $display("FAIL pop_order: got %h expected %h", pop_data, (q.size() == 0) ? 'x : q[0]);
        end
        if (q.size() != 0) void'(q.pop_front());
        popped++;
      end
      if (ram_rd_en) begin
        checks++;
        if (ram_rd_addr !== AW'(rd_total % DEPTH)) begin
          errors++; $display("FAIL rd_addr: got %0d expected %0d", ram_rd_addr, rd_total % DEPTH);
        end
        rd_total++;
      end
      checks++;
      if (push_valid && push_ready) begin
        if (ram_wr_en !== 1'b1 || ram_wr_addr !== AW'(wr_total % DEPTH) || ram_wr_data !== push_data) begin
          errors++; $display("FAIL wr_port: got en=%0b a=%0d expected en=1 a=%0d", ram_wr_en, ram_wr_addr, wr_total % DEPTH);
        end
        q.push_back(push_data);
        wr_total++;
      end else if (ram_wr_en !== 1'b0) begin
        errors++; $display("FAIL wr_idle: got en=%0b expected en=0", ram_wr_en);
      end
      hold_prev = pop_valid && !pop_ready;
      held_data = pop_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  function automatic logic [WIDTH-1:0] rnd73();
    return {9'($urandom), $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_model();
    q.delete(); wr_total = 0; rd_total = 0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    pop_ready = 1'b1; push_valid = 1'b0;
    while (count !== '0 && n < limit) begin tick(); n++; end
    pop_ready = 1'b0;
    checks++;
    if (count !== '0) begin errors++; $display("FAIL drain_timeout: got count=%0d expected 0", count); end
  endtask

  task automatic test_reset();
    rst = 1'b1; push_valid = 1'b0; pop_ready = 1'b0; push_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (push_ready !== 1'b0 || pop_valid !== 1'b0 || ram_wr_en !== 1'b0 || ram_rd_en !== 1'b0 || count !== '0) begin
      errors++; $display("FAIL reset_state: got pr=%0b pv=%0b we=%0b re=%0b cnt=%0d expected 0 0 0 0 0",
                         push_ready, pop_valid, ram_wr_en, ram_rd_en, count);
    end
    clear_model();
    rst = 1'b0;
    #1;
    checks++;
    if (push_ready !== 1'b1 || count !== '0) begin
      errors++; $display("FAIL reset_release: got pr=%0b cnt=%0d expected 1 0", push_ready, count);
    end
    tick();
  endtask

  task automatic test_single();
    push_valid = 1'b1; push_data = 73'h1_2345; pop_ready = 1'b0;
    #1;
    checks++;
    if (ram_wr_en !== 1'b1 || ram_wr_addr !== 4'd0) begin
      errors++; $display("FAIL single_wr: got en=%0b a=%0d expected 1 0", ram_wr_en, ram_wr_addr);
    end
    tick(); push_valid = 1'b0; #1;
    checks++;
    if (ram_rd_en !== 1'b1 || ram_rd_addr !== 4'd0 || pop_valid !== 1'b0) begin
      errors++; $display("FAIL single_rd: got re=%0b a=%0d pv=%0b expected 1 0 0", ram_rd_en, ram_rd_addr, pop_valid);
    end
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if (pop_valid !== 1'b0 || ram_rd_en !== 1'b0) begin
        errors++; $display("FAIL single_early: cycle %0d got pv=%0b re=%0b expected 0 0", i, pop_valid, ram_rd_en);
      end
    end
    tick();
    checks++;
    if (pop_valid !== 1'b1 || pop_data !== 73'h1_2345 || count !== 5'd1) begin
      errors++; $display("FAIL single_pop: got pv=%0b d=%h cnt=%0d expected 1 12345 1", pop_valid, pop_data, count);
    end
    pop_ready = 1'b1;
    tick(); pop_ready = 1'b0;
    checks++;
    if (count !== '0 || pop_valid !== 1'b0) begin
      errors++; $display("FAIL single_after: got cnt=%0d pv=%0b expected 0 0", count, pop_valid);
    end
  endtask

  task automatic test_full();
    int acc = 0;
    int start_pops = popped;
    logic fire;
    pop_ready = 1'b0; push_valid = 1'b1; push_data = rnd73();
    for (int i = 0; i < 20; i++) begin
      #1;
      fire = push_ready;
      if (fire) acc++;
      tick();
      if (fire) push_data = rnd73();
    end
    #1;
    checks++;
    if (acc != 15 || count !== 5'd15 || push_ready !== 1'b0 || pop_valid !== 1'b1) begin
      errors++; $display("FAIL full_state: got acc=%0d cnt=%0d pr=%0b pv=%0b expected 15 15 0 1", acc, count, push_ready, pop_valid);
    end
    push_valid = 1'b0;
    drain(40);
    checks++;
    if (popped - start_pops != 15) begin
      errors++; $display("FAIL full_drain: got %0d pops expected 15", popped - start_pops);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int first_pv = -1;
    int last_pv = -1;
    int pv_cnt = 0;
    int push_done_at = -1;
    push_valid = 1'b1; pop_ready = 1'b1; push_data = WIDTH'(32'hA000_0000);
    for (int c = 0; c < 60; c++) begin
      #1;
      if (pop_valid) begin
        if (first_pv < 0) first_pv = c;
        last_pv = c; pv_cnt++;
      end
      if (push_valid && push_ready) n++;
      tick();
      if (n == 40 && push_done_at < 0) begin push_valid = 1'b0; push_done_at = c; end
      else push_data = WIDTH'(32'hA000_0000) + WIDTH'(n);
    end
    pop_ready = 1'b0;
    checks++;
    if (first_pv != 4 || pv_cnt != 40 || last_pv - first_pv + 1 != 40) begin
      errors++; $display("FAIL stream_bubbles: got first=%0d cnt=%0d span=%0d expected 4 40 40", first_pv, pv_cnt, last_pv - first_pv + 1);
    end
    checks++;
    if (push_done_at != 39) begin
      errors++; $display("FAIL stream_push_rate: got last push cycle %0d expected 39", push_done_at);
    end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    pop_ready = 1'b0; push_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin push_data = rnd73(); tick(); end
    push_valid = 1'b0;
    repeat (5) tick();
    checks++;
    if (count !== 5'd8 || pop_valid !== 1'b1) begin
      errors++; $display("FAIL mid_fill: got cnt=%0d pv=%0b expected 8 1", count, pop_valid);
    end
    pop_ready = 1'b1;
    repeat (3) tick();
    pop_ready = 1'b0;
    #1;
    checks++;
    if (count !== 5'd5) begin errors++; $display("FAIL mid_pre_rst: got cnt=%0d expected 5", count); end
    rst = 1'b1;
    #1;
    checks++;
    if (count !== '0 || pop_valid !== 1'b0 || ram_rd_en !== 1'b0 || push_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rst: got cnt=%0d pv=%0b re=%0b pr=%0b expected 0 0 0 0", count, pop_valid, ram_rd_en, push_ready);
    end
    clear_model();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (pop_valid !== 1'b0 || count !== '0) begin
        errors++; $display("FAIL mid_spurious: cycle %0d got pv=%0b cnt=%0d expected 0 0", i, pop_valid, count);
      end
    end
    push_valid = 1'b1; push_data = 73'hABC;
    tick(); push_valid = 1'b0;
    while (pop_valid !== 1'b1 && w < 10) begin tick(); w++; end
    checks++;
    if (pop_valid !== 1'b1 || pop_data !== 73'hABC) begin
      errors++; $display("FAIL mid_after: got pv=%0b d=%h expected 1 abc", pop_valid, pop_data);
    end
    drain(10);
  endtask

  task automatic test_wrap();
    int guard = 0;
    pop_ready = 1'b1;
    while ((wr_total % DEPTH) != DEPTH - 1 && guard < 40) begin
      push_valid = 1'b1; push_data = rnd73(); tick(); guard++;
    end
    push_valid = 1'b0;
    drain(20);
    pop_ready = 1'b1;
    push_valid = 1'b1; push_data = rnd73();
    #1;
    checks++;
    if (ram_wr_en !== 1'b1 || ram_wr_addr !== 4'd11 || ram_rd_en !== 1'b0) begin
      errors++; $display("FAIL wrap_wr11: got we=%0b a=%0d re=%0b expected 1 11 0", ram_wr_en, ram_wr_addr, ram_rd_en);
    end
    tick();
    push_data = rnd73();
    #1;
    checks++;
    if (ram_rd_en !== 1'b1 || ram_rd_addr !== 4'd11 || ram_wr_en !== 1'b1 || ram_wr_addr !== 4'd0) begin
      errors++; $display("FAIL wrap_next: got re=%0b ra=%0d we=%0b wa=%0d expected 1 11 1 0", ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr);
    end
    tick();
    push_valid = 1'b0;
    drain(20);
  endtask

  task automatic test_random();
    int sent = 0;
    int cyc = 0;
    int start_pops = popped;
    logic pend = 1'b0;
    logic fire;
    push_valid = 1'b0; pop_ready = 1'b0;
    while ((sent < 500 || count !== '0) && cyc < 20000) begin
      if (!pend) begin
        push_valid = (sent < 500) && ($urandom_range(0, 1) == 1);
        push_data  = rnd73();
      end
      pop_ready = ($urandom_range(0, 1) == 1);
      #1;
      fire = push_valid && push_ready;
      pend = push_valid && !fire;
      if (fire) sent++;
      tick();
      cyc++;
    end
    push_valid = 1'b0; pop_ready = 1'b0;
    checks++;
    if (sent != 500 || count !== '0) begin
      errors++; $display("FAIL random_timeout: got sent=%0d cnt=%0d expected 500 0", sent, count);
    end
    checks++;
    if (popped - start_pops != 500) begin
      errors++; $display("FAIL random_pops: got %0d expected 500", popped - start_pops);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; push_valid = 1'b0; pop_ready = 1'b0; push_data = '0;
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
